// File: rtl/traffic_light_countdown.sv
// Traffic-light sequencer RED->GREEN->YELLOW with a BCD countdown on two 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module traffic_light_countdown #(
  parameter int RED_TIME    = 12,
  parameter int GREEN_TIME  = 88,
  parameter int YELLOW_TIME = 3,
  parameter int TICK_DIV    = 1,
  parameter int REQ_TRUNC   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       REQ,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [6:0] seg1,
  output logic [6:0] seg2
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  localparam logic [7:0] RED_BCD    = to_bcd(RED_TIME);
  localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_TIME);
  localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_TIME);
  localparam logic [7:0] TRUNC_BCD  = to_bcd(REQ_TRUNC);

  typedef enum logic [1:0] {S_RED, S_GREEN, S_YELLOW} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            tick;
  logic            trunc;

  function automatic logic [7:0] bcd_dec(input logic [7:0] c);
    if (c[3:0] == 4'd0) return {c[7:4] - 4'd1, 4'd9};
    return {c[7:4], c[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1110011;
      default: return 7'b0000000;
    endcase
  endfunction

  assign tick  = EN && (presc_q == PRESC_LAST);
  // BCD digits compare correctly as a plain unsigned byte.
  assign trunc = EN && REQ && (state_q == S_GREEN) && (cnt_q > TRUNC_BCD);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (trunc) begin
      cnt_d   = TRUNC_BCD;
      presc_d = '0;
    end else if (EN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (cnt_q == 8'h01) begin
          case (state_q)
            S_RED:    begin state_d = S_GREEN;  cnt_d = GREEN_BCD;  end
            S_GREEN:  begin state_d = S_YELLOW; cnt_d = YELLOW_BCD; end
            default:  begin state_d = S_RED;    cnt_d = RED_BCD;    end
          endcase
        end else begin
          cnt_d = bcd_dec(cnt_q);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RED;
      presc_q <= '0;
      cnt_q   <= RED_BCD;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign red    = (state_q == S_RED);
  assign green  = (state_q == S_GREEN);
  assign yellow = (state_q == S_YELLOW);
  assign seg1   = seg_decode(cnt_q[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
  assign seg2   = (cnt_q[7:4] == 4'd0) ? 7'b0000000 : seg_decode(cnt_q[7:4]);
`else
  assign seg2   = seg_decode(cnt_q[7:4]);
`endif

endmodule

// File: tb/tb_traffic_light_countdown.sv
// Bench for traffic_light_countdown: two parameterisations driven by shared random stimulus,
// checked every cycle against an integer-count behavioural model plus literal pins.
module tb_traffic_light_countdown;

  logic CLK = 1'b0;
  logic RST, EN, REQ;
  logic ra, ya, ga, rb, yb, gb;
  logic [6:0] s1a, s2a, s1b, s2b;

  traffic_light_countdown u_a (
    .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
    .red(ra), .yellow(ya), .green(ga), .seg1(s1a), .seg2(s2a)
  );

  traffic_light_countdown #(
    .RED_TIME(2), .GREEN_TIME(15), .YELLOW_TIME(4), .TICK_DIV(4), .REQ_TRUNC(5)
  ) u_b (
    .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
    .red(rb), .yellow(yb), .green(gb), .seg1(s1b), .seg2(s2b)
  );

  always #5 CLK = ~CLK;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z0 = 7'b0000000;
`else
  localparam logic [6:0] Z0 = 7'b1111110;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: state 0=RED 1=GREEN 2=YELLOW, count as a plain integer.
  int T  [2][3] = '{'{12, 88, 3}, '{2, 15, 4}};
  int TD [2]    = '{1, 4};
  int TR [2]    = '{5, 5};
  int st [2];
  int cnt[2];
  int pre[2];

  logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  always @(posedge CLK or posedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        st[i] = 0; cnt[i] = T[i][0]; pre[i] = 0;
      end else if (EN) begin
        if (st[i] == 1 && cnt[i] > TR[i] && REQ) begin
          cnt[i] = TR[i]; pre[i] = 0;
        end else if (pre[i] == TD[i] - 1) begin
          pre[i] = 0;
          if (cnt[i] == 1) begin
            st[i]  = (st[i] + 1) % 3;
            cnt[i] = T[i][st[i]];
          end else begin
            cnt[i] = cnt[i] - 1;
          end
        end else begin
          pre[i] = pre[i] + 1;
        end
      end
    end
  end

  function automatic logic [6:0] tens_pat(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0) return 7'b0000000;
`endif
    return PAT[d];
  endfunction

  function automatic logic [16:0] exp_vec(input int i);
    return {st[i] == 0, st[i] == 2, st[i] == 1, tens_pat(cnt[i] / 10), PAT[cnt[i] % 10]};
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("u_a_model", {ra, ya, ga, s2a, s1a}, exp_vec(0));
    chk("u_b_model", {rb, yb, gb, s2b, s1b}, exp_vec(1));
  endtask

  always @(negedge CLK) if (chk_en && !RST) chk_model();

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int n;
    RST = 1'b1; EN = 1'b0; REQ = 1'b0;
    cyc(3);
    RST = 1'b0; EN = 1'b1; chk_en = 1'b1;
    chk("reset_a", {ra, ya, ga, s2a, s1a}, {3'b100, 7'b0110000, 7'b1101101});
    chk("reset_b", {rb, yb, gb, s2b, s1b}, {3'b100, Z0, 7'b1101101});
    cyc(4);
    chk("b_div4_hold1", {rb, yb, gb, s2b, s1b}, {3'b100, Z0, 7'b0110000});
    cyc(4);
    chk("b_green_at8", {rb, yb, gb, s2b, s1b}, {3'b001, 7'b0110000, 7'b1011011});
    cyc(4);
    chk("a_green88", {ra, ya, ga, s2a, s1a}, {3'b001, 7'b1111111, 7'b1111111});
    cyc(78);
    chk("a_green10", {ra, ya, ga, s2a, s1a}, {3'b001, 7'b0110000, 7'b1111110});
    cyc(1);
    chk("a_borrow09", {ra, ya, ga, s2a, s1a}, {3'b001, Z0, 7'b1110011});
    cyc(1);
    chk("a_green08", {ra, ya, ga, s2a, s1a}, {3'b001, Z0, 7'b1111111});
    cyc(8);
    chk("a_yellow03", {ra, ya, ga, s2a, s1a}, {3'b010, Z0, 7'b1111001});
    cyc(3);
    chk("a_red12", {ra, ya, ga, s2a, s1a}, {3'b100, 7'b0110000, 7'b1101101});
    cyc(12);
    cyc(48);
    chk("a_green40", {ra, ya, ga, s2a, s1a}, {3'b001, 7'b0110011, 7'b1111110});
    REQ = 1'b1;
    cyc(1);
    chk("a_trunc05", {ra, ya, ga, s2a, s1a}, {3'b001, Z0, 7'b1011011});
    cyc(1);
    chk("a_req_again04", {ra, ya, ga, s2a, s1a}, {3'b001, Z0, 7'b0110011});
    REQ = 1'b0;

    repeat (3000) begin
      @(negedge CLK);
      EN  = ($urandom % 8) != 0;
      REQ = ($urandom % 12) == 0;
    end

    EN = 1'b1; REQ = 1'b0;
    n = 0;
    while (!(st[0] == 1 && cnt[0] == 50) && n < 400) begin
      @(negedge CLK); n++;
    end
    chk("wait_green50", {16'd0, n < 400}, 17'd1);
    EN = 1'b0;
    cyc(10);
    chk("a_en_hold50", {ra, ya, ga, s2a, s1a}, {3'b001, 7'b1011011, 7'b1111110});
    EN = 1'b1;
    cyc(1);
    chk("a_resume49", {ra, ya, ga, s2a, s1a}, {3'b001, 7'b0110011, 7'b1110011});

    n = 0;
    while (st[0] != 2 && n < 400) begin
      @(negedge CLK); n++;
    end
    chk("wait_yellow", {16'd0, n < 400}, 17'd1);
    #2 RST = 1'b1;
    #1;
    chk("a_async_reset", {ra, ya, ga, s2a, s1a}, {3'b100, 7'b0110000, 7'b1101101});
    chk_model();
    cyc(2);
    RST = 1'b0;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
